// File: rtl/egg_timer_pkg.sv
// egg_timer_pkg: shared types and constants for the egg timer countdown block.
package egg_timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_DASH   = 4'hF;
  localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [DIGIT_W-1:0] digit_t;

  // MM:SS as four BCD digits, most significant first
  typedef struct packed {
    digit_t min_tens;
    digit_t min_ones;
    digit_t sec_tens;
    digit_t sec_ones;
  } mmss_t;

endpackage

// File: rtl/egg_tick_gen.sv
// egg_tick_gen: free-running prescaler that pulses tick for one cycle every
// CLK_HZ enabled cycles. sync_clr restarts the count from zero.
module egg_tick_gen #(
  parameter int unsigned CLK_HZ = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic sync_clr,
  output logic tick
);

  localparam int unsigned      CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CNT_W-1:0] TERM  = CNT_W'(CLK_HZ - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count while enabled, wrapping at the terminal count; clear has priority
  always_comb begin
    cnt_d = cnt_q;
    if (sync_clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == TERM) ? '0 : cnt_q + 1'b1;
    end
  end

  // Prescaler count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !sync_clr && (cnt_q == TERM);

endmodule

// File: rtl/egg_timer_ctrl.sv
// egg_timer_ctrl: MM:SS countdown sequencer driving four 7-segment decoders.
// Optional build macro EGG_TIMER_BLINK_EN: blink the display 0000/----
// while the alarm is active.
module egg_timer_ctrl
  import egg_timer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned BLINK_HZ_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_stop,
  input  logic               clear,
  input  logic               inc_min,
  input  logic               inc_sec,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               alarm
);

  if (CLK_HZ < 1 || BLINK_HZ_DIV < 1 || CLK_HZ < BLINK_HZ_DIV) begin : g_bad_cfg
    $error("egg_timer_ctrl: CLK_HZ and BLINK_HZ_DIV must be >= 1 with CLK_HZ >= BLINK_HZ_DIV");
  end

  localparam mmss_t ONE_SEC = '{min_tens: 4'd0, min_ones: 4'd0, sec_tens: 4'd0, sec_ones: 4'd1};

  state_e state_q, state_d;
  mmss_t  time_q, time_d;
  logic   running_q, running_d;
  logic   alarm_q, alarm_d;
  logic   pre_clr;
  logic   sec_tick;
  logic   editable;
  logic   run_en;

  function automatic mmss_t add_sec(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_ones == 4'd9) begin
      r.sec_ones = '0;
      r.sec_tens = (t.sec_tens == SEC_TENS_MAX) ? '0 : t.sec_tens + 4'd1;
    end else begin
      r.sec_ones = t.sec_ones + 4'd1;
    end
    return r;
  endfunction

  function automatic mmss_t add_min(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.min_ones == 4'd9) begin
      r.min_ones = '0;
      r.min_tens = (t.min_tens == 4'd9) ? '0 : t.min_tens + 4'd1;
    end else begin
      r.min_ones = t.min_ones + 4'd1;
    end
    return r;
  endfunction

  // Caller guarantees t != 00:00, so the final min_tens borrow cannot underflow
  function automatic mmss_t dec_time(input mmss_t t);
    mmss_t r;
    r = t;
    if (t.sec_ones != 4'd0) begin
      r.sec_ones = t.sec_ones - 4'd1;
    end else begin
      r.sec_ones = 4'd9;
      if (t.sec_tens != 4'd0) begin
        r.sec_tens = t.sec_tens - 4'd1;
      end else begin
        r.sec_tens = SEC_TENS_MAX;
        if (t.min_ones != 4'd0) begin
          r.min_ones = t.min_ones - 4'd1;
        end else begin
          r.min_ones = 4'd9;
          r.min_tens = t.min_tens - 4'd1;
        end
      end
    end
    return r;
  endfunction

  assign run_en = (state_q == RUN);

  egg_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (run_en),
    .sync_clr(pre_clr),
    .tick    (sec_tick)
  );

  // Next state and time: clear > start_stop > inc_min > inc_sec > countdown tick
  always_comb begin
    state_d  = state_q;
    time_d   = time_q;
    pre_clr  = 1'b0;
    editable = (state_q == IDLE) || (state_q == PAUSE);
    if (clear) begin
      state_d = IDLE;
      time_d  = '0;
      pre_clr = 1'b1;
    end else if (start_stop) begin
      unique case (state_q)
        IDLE, PAUSE: begin
          if (time_q != '0) begin
            state_d = RUN;
            pre_clr = 1'b1;
          end
        end
        RUN:  state_d = PAUSE;
        DONE: begin
          state_d = IDLE;
          time_d  = '0;
        end
        default: state_d = IDLE;
      endcase
    end else if (inc_min && editable) begin
      time_d = add_min(time_q);
    end else if (inc_sec && editable) begin
      time_d = add_sec(time_q);
    end else if (sec_tick && run_en && (time_q != '0)) begin
      time_d = dec_time(time_q);
      if (time_q == ONE_SEC) begin
        state_d = DONE;
      end
    end
  end

`ifdef EGG_TIMER_BLINK_EN
  localparam int unsigned BLINK_CYC = CLK_HZ / BLINK_HZ_DIV;

  logic  blink_en, blink_clr, blink_tick;
  logic  phase_q, phase_d;
  mmss_t disp_q, disp_d;

  assign blink_en  = (state_q == DONE);
  assign blink_clr = (state_q != DONE);

  egg_tick_gen #(
    .CLK_HZ(BLINK_CYC)
  ) u_blink_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (blink_en),
    .sync_clr(blink_clr),
    .tick    (blink_tick)
  );

  // Blink phase: forced to 0 outside DONE so every DONE entry starts on 0000
  always_comb begin
    phase_d = phase_q;
    if (state_d != DONE) begin
      phase_d = 1'b0;
    end else if (blink_tick) begin
      phase_d = ~phase_q;
    end
  end

  // Blink phase and registered display digits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      phase_q <= phase_d;
      disp_q  <= disp_d;
    end
  end

  assign min_tens = disp_q.min_tens;
  assign min_ones = disp_q.min_ones;
  assign sec_tens = disp_q.sec_tens;
  assign sec_ones = disp_q.sec_ones;
`else
  assign min_tens = time_q.min_tens;
  assign min_ones = time_q.min_ones;
  assign sec_tens = time_q.sec_tens;
  assign sec_ones = time_q.sec_ones;
`endif

  // Output decode from the next state so status flags register alongside the digits
  always_comb begin
    running_d = (state_d == RUN);
    alarm_d   = (state_d == DONE);
`ifdef EGG_TIMER_BLINK_EN
    disp_d = time_d;
    if (state_d == DONE && phase_d) begin
      disp_d = '{min_tens: DIGIT_DASH, min_ones: DIGIT_DASH,
                 sec_tens: DIGIT_DASH, sec_ones: DIGIT_DASH};
    end
`endif
  end

  // State, time and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      time_q    <= '0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end

  assign running = running_q;
  assign alarm   = alarm_q;

endmodule

// File: tb/tb_egg_timer_ctrl.sv
// tb_egg_timer_ctrl: directed self-checking bench for egg_timer_ctrl
// (CLK_HZ=10, BLINK_HZ_DIV=2). Honors EGG_TIMER_BLINK_EN when defined.
module tb_egg_timer_ctrl;

  localparam int unsigned CLK_HZ       = 10;
  localparam int unsigned BLINK_HZ_DIV = 2;

  logic       clk        = 1'b0;
  logic       rst_n      = 1'b0;
  logic       start_stop = 1'b0;
  logic       clear      = 1'b0;
  logic       inc_min    = 1'b0;
  logic       inc_sec    = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, alarm;
  logic [15:0] shown;
  logic [15:0] dash_exp;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  egg_timer_ctrl #(
    .CLK_HZ      (CLK_HZ),
    .BLINK_HZ_DIV(BLINK_HZ_DIV)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_stop(start_stop),
    .clear     (clear),
    .inc_min   (inc_min),
    .inc_sec   (inc_sec),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .running   (running),
    .alarm     (alarm)
  );

  assign shown = {min_tens, min_ones, sec_tens, sec_ones};

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold the requested inputs for exactly one sampling edge
  task automatic pulse(input logic ss, input logic cl, input logic im, input logic is);
    start_stop = ss;
    clear      = cl;
    inc_min    = im;
    inc_sec    = is;
    @(posedge clk);
    #1;
    start_stop = 1'b0;
    clear      = 1'b0;
    inc_min    = 1'b0;
    inc_sec    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef EGG_TIMER_BLINK_EN
    dash_exp = 16'hFFFF;
`else
    dash_exp = 16'h0000;
`endif
    // Reset values
    step(3);
    check("rst_time", shown, 16'h0000);
    check("rst_run", 16'(running), 16'd0);
    check("rst_alarm", 16'(alarm), 16'd0);
    rst_n = 1'b1;
    step(1);

    // Set 00:03 and count down to alarm
    for (int i = 0; i < 3; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("set3", shown, 16'h0003);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("start_run", 16'(running), 16'd1);
    step(9);
    check("pre_tick1", shown, 16'h0003);
    step(1);
    check("tick1", shown, 16'h0002);
    step(19);
    check("pre_last", shown, 16'h0001);
    check("pre_last_alarm", 16'(alarm), 16'd0);
    step(1);
    check("zero_time", shown, 16'h0000);
    check("zero_alarm", 16'(alarm), 16'd1);
    check("zero_run", 16'(running), 16'd0);

    // Display while in DONE
    step(4);
    check("blink_p0", shown, 16'h0000);
    step(1);
    check("blink_p1a", shown, dash_exp);
    step(4);
    check("blink_p1b", shown, dash_exp);
    step(1);
    check("blink_p0b", shown, 16'h0000);
    step(5);
    check("blink_p1c", shown, dash_exp);
    check("done_alarm", 16'(alarm), 16'd1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("ack_time", shown, 16'h0000);
    check("ack_alarm", 16'(alarm), 16'd0);
    check("ack_run", 16'(running), 16'd0);

    // Borrow through all digits: 10:00 -> 09:59
    for (int i = 0; i < 10; i++) pulse(1'b0, 1'b0, 1'b1, 1'b0);
    check("set10m", shown, 16'h1000);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(9);
    check("borrow_pre", shown, 16'h1000);
    step(1);
    check("borrow", shown, 16'h0959);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("incsec_in_run", shown, 16'h0959);
    step(9);
    check("tick_after_inc", shown, 16'h0958);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    check("clr_over_ss_time", shown, 16'h0000);
    check("clr_over_ss_run", 16'(running), 16'd0);
    step(12);
    check("idle_after_clr", shown, 16'h0000);

    // Edit wraps
    for (int i = 1; i <= 61; i++) begin
      pulse(1'b0, 1'b0, 1'b0, 1'b1);
      if (i == 59) check("sec59", shown, 16'h0059);
      if (i == 60) check("sec_wrap", shown, 16'h0000);
    end
    check("sec61", shown, 16'h0001);
    for (int i = 1; i <= 100; i++) begin
      pulse(1'b0, 1'b0, 1'b1, 1'b0);
      if (i == 99) check("min99", shown, 16'h9901);
    end
    check("min_wrap", shown, 16'h0001);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("ss_at_zero_run", 16'(running), 16'd0);
    step(12);
    check("ss_at_zero_time", shown, 16'h0000);
    check("ss_at_zero_alarm", 16'(alarm), 16'd0);

    // Same-cycle priority in IDLE
    pulse(1'b0, 1'b0, 1'b1, 1'b1);
    check("min_over_sec", shown, 16'h0100);
    pulse(1'b1, 1'b0, 1'b1, 1'b0);
    check("ss_over_min_time", shown, 16'h0100);
    check("ss_over_min_run", 16'(running), 16'd1);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);

    // Pause and resume
    for (int i = 0; i < 5; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("set5", shown, 16'h0005);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    step(10);
    check("p_tick", shown, 16'h0004);
    step(4);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("pause_run", 16'(running), 16'd0);
    step(30);
    check("pause_frozen", shown, 16'h0004);
    check("pause_run2", 16'(running), 16'd0);
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    check("pause_incsec", shown, 16'h0005);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    check("resume_run", 16'(running), 16'd1);
    step(9);
    check("resume_pre", shown, 16'h0005);
    step(1);
    check("resume_tick", shown, 16'h0004);

    // Asynchronous reset while running
    step(3);
    rst_n = 1'b0;
    #1;
    check("async_rst_time", shown, 16'h0000);
    check("async_rst_run", 16'(running), 16'd0);
    step(2);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
